hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencing controller beside the EX forwarding unit. Handles every hazard that

---
 rtl/hazard_stall_ctrl_pkg.sv | 22 ++
 rtl/hazard_stall_ctrl_if.sv | 41 ++++
 rtl/hazard_stall_ctrl_sat_counter.sv | 20 ++
 rtl/hazard_stall_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard/stall controller.
package hazard_stall_ctrl_pkg;

  localparam int unsigned DEF_REG_SEL_W   = 3;
  localparam int unsigned DEF_MEM_TIMEOUT = 64;
  localparam int unsigned DEF_PERF_CNT_W  = 16;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALTED   = 2'd2;

  typedef enum logic [1:0] {
    RUN      = ST_RUN,
    MEM_WAIT = ST_MEM_WAIT,
    HALTED   = ST_HALTED
  } state_t;

  // Opcodes the decode stage uses to inject a bubble and to recognise HALT.
  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Decode-stage hazard inputs and pipeline enable/flush outputs.
interface hazard_stall_ctrl_if #(
  parameter int unsigned REG_SEL_W  = 3,
  parameter int unsigned PERF_CNT_W = 16
);
  logic [REG_SEL_W-1:0]  read1RegSel_ID;
  logic [REG_SEL_W-1:0]  read2RegSel_ID;
  logic                  read1_used_ID;
  logic                  read2_used_ID;
  logic                  MemRead_EX;
  logic                  RegWrite_EX;
  logic [REG_SEL_W-1:0]  Write_register_EX;
  logic                  dmem_Stall;
  logic                  dmem_Done;
  logic                  branch_taken_EX;
  logic                  halt_WB;
  logic                  stall_PC;
  logic                  stall_IFID;
  logic                  bubble_IDEX;
  logic                  freeze_pipe;
  logic                  flush_IFID;
  logic                  flush_IDEX;
  logic                  timeout_err;
  logic [PERF_CNT_W-1:0] stall_count;

  modport master (
    output read1RegSel_ID, read2RegSel_ID, read1_used_ID, read2_used_ID,
           MemRead_EX, RegWrite_EX, Write_register_EX, dmem_Stall, dmem_Done,
           branch_taken_EX, halt_WB,
    input  stall_PC, stall_IFID, bubble_IDEX, freeze_pipe, flush_IFID, flush_IDEX,
           timeout_err, stall_count
  );

  modport slave (
    input  read1RegSel_ID, read2RegSel_ID, read1_used_ID, read2_used_ID,
           MemRead_EX, RegWrite_EX, Write_register_EX, dmem_Stall, dmem_Done,
           branch_taken_EX, halt_WB,
    output stall_PC, stall_IFID, bubble_IDEX, freeze_pipe, flush_IFID, flush_IDEX,
           timeout_err, stall_count
  );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage sequencing: load-use bubbles, memory freezes, branch flushes and halt.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned REG_SEL_W   = DEF_REG_SEL_W,
  parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int unsigned PERF_CNT_W  = DEF_PERF_CNT_W
) (
  input logic               clk,
  input logic               rst,
  hazard_stall_ctrl_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t                state;
  state_t                state_nxt;
  logic                  timeout_err_q;
  logic [REG_SEL_W-1:0]  dst;
  logic                  hit1;
  logic                  hit2;
  logic                  lu;
  logic                  wait_inc;
  logic                  wait_clr;
  logic                  wait_last;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [PERF_CNT_W-1:0] stall_cnt;
  logic                  stall_pc;
  logic                  stall_ifid;
  logic                  bubble;
  logic                  freeze;
  logic                  flush_ifid;
  logic                  flush_idex;

  // Load-use: EX load writes a register the ID instruction really reads.
  assign dst       = bus.Write_register_EX;
  assign hit1      = bus.read1_used_ID && (bus.read1RegSel_ID == dst);
  assign hit2      = bus.read2_used_ID && (bus.read2RegSel_ID == dst);
  assign lu        = bus.MemRead_EX && bus.RegWrite_EX && (hit1 || hit2);
  assign wait_last = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    wait_inc   = 1'b0;
    wait_clr   = 1'b0;
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    bubble     = 1'b0;
    freeze     = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (bus.dmem_Stall) begin
            freeze     = 1'b1;
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            if (!bus.dmem_Done) state_nxt = MEM_WAIT;
          end else if (bus.branch_taken_EX) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (lu) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            bubble     = 1'b1;
          end else if (bus.halt_WB) begin
            state_nxt = HALTED;
          end
        end
        MEM_WAIT: begin
          // Done releases the freeze in the same cycle; hazards resume next cycle.
          if (bus.dmem_Done) begin
            wait_clr  = 1'b1;
            state_nxt = RUN;
          end else begin
            wait_inc   = 1'b1;
            freeze     = 1'b1;
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
          end
        end
        HALTED: begin
          freeze     = 1'b1;
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      timeout_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wait_inc && wait_last) timeout_err_q <= 1'b1;
    end
  end

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wait_inc),
    .clr (wait_clr),
    .q   (wait_cnt)
  );

  sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_pc),
    .clr (1'b0),
    .q   (stall_cnt)
  );

  assign bus.stall_PC    = stall_pc;
  assign bus.stall_IFID  = stall_ifid;
  assign bus.bubble_IDEX = bubble;
  assign bus.freeze_pipe = freeze;
  assign bus.flush_IFID  = flush_ifid;
  assign bus.flush_IDEX  = flush_idex;
  assign bus.timeout_err = timeout_err_q;
  assign bus.stall_count = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: default instance plus a MEM_TIMEOUT=4 instance.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int unsigned RW = 3;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_SEL_W(RW), .PERF_CNT_W(CW)) bus64 ();
  hazard_stall_ctrl_if #(.REG_SEL_W(RW), .PERF_CNT_W(CW)) bus4 ();

  hazard_stall_ctrl #(.REG_SEL_W(RW), .MEM_TIMEOUT(64), .PERF_CNT_W(CW)) dut (
    .clk (clk), .rst (rst), .bus (bus64.slave));
  hazard_stall_ctrl #(.REG_SEL_W(RW), .MEM_TIMEOUT(4), .PERF_CNT_W(CW)) dut_to4 (
    .clk (clk), .rst (rst), .bus (bus4.slave));

  assign bus4.read1RegSel_ID    = bus64.read1RegSel_ID;
  assign bus4.read2RegSel_ID    = bus64.read2RegSel_ID;
  assign bus4.read1_used_ID     = bus64.read1_used_ID;
  assign bus4.read2_used_ID     = bus64.read2_used_ID;
  assign bus4.MemRead_EX        = bus64.MemRead_EX;
  assign bus4.RegWrite_EX       = bus64.RegWrite_EX;
  assign bus4.Write_register_EX = bus64.Write_register_EX;
  assign bus4.dmem_Stall        = bus64.dmem_Stall;
  assign bus4.dmem_Done         = bus64.dmem_Done;
  assign bus4.branch_taken_EX   = bus64.branch_taken_EX;
  assign bus4.halt_WB           = bus64.halt_WB;

  typedef struct packed {
    logic          spc, sif, bub, frz, fif, fid, to64, to4;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  state_t m_state;
  int     m_w64, m_w4, m_cnt;
  logic   m_to64, m_to4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_state = RUN; m_w64 = 0; m_w4 = 0; m_cnt = 0; m_to64 = 1'b0; m_to4 = 1'b0;
  endtask

  task automatic idle();
    bus64.read1RegSel_ID = '0; bus64.read2RegSel_ID = '0;
    bus64.read1_used_ID = 1'b0; bus64.read2_used_ID = 1'b0;
    bus64.MemRead_EX = 1'b0; bus64.RegWrite_EX = 1'b0; bus64.Write_register_EX = '0;
    bus64.dmem_Stall = 1'b0; bus64.dmem_Done = 1'b0;
    bus64.branch_taken_EX = 1'b0; bus64.halt_WB = 1'b0;
  endtask

  task automatic load_use_setup();
    bus64.MemRead_EX = 1'b1; bus64.RegWrite_EX = 1'b1; bus64.Write_register_EX = 3'd3;
    bus64.read1RegSel_ID = 3'd3; bus64.read1_used_ID = 1'b1;
  endtask

  // One clock: push expectation, compare at negedge, then advance the model at posedge.
  task automatic cycle(input string tag);
    exp_t e;
    exp_t g;
    logic lu;
    lu = bus64.MemRead_EX && bus64.RegWrite_EX &&
         ((bus64.read1_used_ID && bus64.read1RegSel_ID == bus64.Write_register_EX) ||
          (bus64.read2_used_ID && bus64.read2RegSel_ID == bus64.Write_register_EX));
    e = '0;
    e.to64 = m_to64; e.to4 = m_to4; e.cnt = CW'(m_cnt);
    if (!rst) begin
      if (m_state == HALTED) begin
        e.spc = 1'b1; e.sif = 1'b1; e.frz = 1'b1;
      end else if (m_state == MEM_WAIT) begin
        if (!bus64.dmem_Done) begin e.spc = 1'b1; e.sif = 1'b1; e.frz = 1'b1; end
      end else if (bus64.dmem_Stall) begin
        e.spc = 1'b1; e.sif = 1'b1; e.frz = 1'b1;
      end else if (bus64.branch_taken_EX) begin
        e.fif = 1'b1; e.fid = 1'b1;
      end else if (lu) begin
        e.spc = 1'b1; e.sif = 1'b1; e.bub = 1'b1;
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    check({tag, ".stall_PC"},    32'(bus64.stall_PC),    32'(g.spc));
    check({tag, ".stall_IFID"},  32'(bus64.stall_IFID),  32'(g.sif));
    check({tag, ".bubble_IDEX"}, 32'(bus64.bubble_IDEX), 32'(g.bub));
    check({tag, ".freeze_pipe"}, 32'(bus64.freeze_pipe), 32'(g.frz));
    check({tag, ".flush_IFID"},  32'(bus64.flush_IFID),  32'(g.fif));
    check({tag, ".flush_IDEX"},  32'(bus64.flush_IDEX),  32'(g.fid));
    check({tag, ".timeout64"},   32'(bus64.timeout_err), 32'(g.to64));
    check({tag, ".timeout4"},    32'(bus4.timeout_err),  32'(g.to4));
    check({tag, ".stall_count"}, 32'(bus64.stall_count), 32'(g.cnt));
    check({tag, ".freeze4"},     32'(bus4.freeze_pipe),  32'(g.frz));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (g.spc && m_cnt != (2**CW) - 1) m_cnt++;
      case (m_state)
        RUN: begin
          if (bus64.dmem_Stall) begin
            if (!bus64.dmem_Done) m_state = MEM_WAIT;
          end else if (!bus64.branch_taken_EX && !lu && bus64.halt_WB) begin
            m_state = HALTED;
          end
        end
        MEM_WAIT: begin
          if (bus64.dmem_Done) begin
            m_state = RUN; m_w64 = 0; m_w4 = 0;
          end else begin
            if (m_w64 == 63) m_to64 = 1'b1;
            if (m_w4 == 3) m_to4 = 1'b1;
            m_w64++; m_w4++;
          end
        end
        default: ;
      endcase
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle("reset");
    rst = 1'b0;
    cycle("idle");

    load_use_setup();
    cycle("lu");
    idle();
    cycle("lu_next");
    check("lu_count", 32'(bus64.stall_count), 32'd1);

    load_use_setup();
    bus64.read1RegSel_ID = 3'd5; bus64.read2RegSel_ID = 3'd3; bus64.read2_used_ID = 1'b0;
    cycle("nohaz");
    bus64.read2_used_ID = 1'b1; bus64.read1_used_ID = 1'b0;
    cycle("lu_rt");

    load_use_setup();
    bus64.branch_taken_EX = 1'b1;
    cycle("br_lu");
    idle();
    cycle("br_after");

    bus64.dmem_Stall = 1'b1; bus64.dmem_Done = 1'b1;
    cycle("stall_done_same");
    idle();
    cycle("stall_done_after");

    for (int i = 0; i < 5; i++) begin
      idle();
      bus64.dmem_Stall = 1'b1;
      if (i == 2) begin
        bus64.branch_taken_EX = 1'b1;
        load_use_setup();
      end
      cycle($sformatf("memwait%0d", i));
    end
    idle();
    bus64.dmem_Done = 1'b1;
    cycle("mem_done");
    idle();
    cycle("mem_after");

    rst = 1'b1;
    cycle("rst_pre_to");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle();
      bus64.dmem_Stall = 1'b1;
      cycle($sformatf("timeout%0d", i));
    end
    check("timeout4_set", 32'(bus4.timeout_err), 32'd1);
    check("timeout64_clear", 32'(bus64.timeout_err), 32'd0);
    rst = 1'b1;
    cycle("rst_mid_wait");
    rst = 1'b0;
    idle();
    cycle("after_wait_rst");

    bus64.halt_WB = 1'b1;
    cycle("halt");
    idle();
    for (int i = 0; i < 20; i++) begin
      bus64.branch_taken_EX = (i % 3 == 0);
      bus64.dmem_Done = (i % 5 == 1);
      cycle($sformatf("halted%0d", i));
    end
    idle();
    rst = 1'b1;
    cycle("rst_halt");
    rst = 1'b0;
    cycle("post_halt");
    check("post_halt_count", 32'(bus64.stall_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
